// File: rtl/pcie_tlp_pkg.sv
// Shared definitions for the PCIe tag tracker.
// Holds the completion status codes, the tracker's internal retirement codes,
// the tag base used in 10-bit tag mode, the per-entry state record and a
// helper that decodes the 12-bit completion Byte Count field.
package pcie_tlp_pkg;

    // Completion status values as they appear in the completion header
    localparam logic [2:0] ST_SC       = 3'b000;
    localparam logic [2:0] ST_UR       = 3'b001;
    localparam logic [2:0] ST_CRS      = 3'b010;
    localparam logic [2:0] ST_CA       = 3'b100;

    // Tracker-generated retirement reasons (never seen on the wire)
    localparam logic [2:0] ST_MISMATCH = 3'b110;
    localparam logic [2:0] ST_TIMEOUT  = 3'b111;

    // 10-bit tags are handed out starting at this value
    localparam int TAG_BASE_10BIT = 256;

    // Per-tag bookkeeping
    typedef struct packed {
        logic        busy;
        logic        expired;
        logic [12:0] remaining;
        logic [7:0]  timer;
    } tag_entry_t;

    // A Byte Count of zero stands for a full 4 KB
    function automatic logic [12:0] decode_byte_count(input logic [11:0] bc);
        return (bc == 12'd0) ? 13'd4096 : {1'b0, bc};
    endfunction

endpackage

// File: rtl/tlp_tag_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   i_vec   - request vector, bit 0 has highest priority
//   o_idx   - index of the lowest set bit (0 when none set)
//   o_found - at least one bit of i_vec is set
module tlp_tag_prio_enc #(
    parameter int N  = 32,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlp_tag_tracker.sv
// Outstanding non-posted request tracker.
// Hands out tags to the header builder, matches returning completions
// against them, counts down remaining bytes to spot the final completion and
// retires stale tags after a programmable timeout.
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_tag_10bit_en          - requested tag mode, sampled only while idle
//   i_alloc_valid/_byte_cnt - tag request and its byte count (1..4096)
//   o_alloc_ready/_tag      - a free tag exists / the tag that would be granted
//   i_cpl_*                 - completion header fields, one per cycle max
//   o_done_valid/_tag/_st   - one-cycle retirement pulse with reason
//   o_err_unexpected        - completion for a tag that is not outstanding
//   o_outstanding_cnt       - number of busy entries
//   o_mode_10bit            - currently latched tag mode
module tlp_tag_tracker
    import pcie_tlp_pkg::*;
#(
    parameter int SUPPORT_10BIT_TAG = 0,
    parameter int NUM_TAGS          = 32,
    parameter int TICK_DIV          = 1024,
    parameter int TIMEOUT_TICKS     = 50
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tag_10bit_en,
    input  logic        i_alloc_valid,
    input  logic [12:0] i_alloc_byte_count,
    output logic        o_alloc_ready,
    output logic [9:0]  o_alloc_tag,
    input  logic        i_cpl_valid,
    input  logic [9:0]  i_cpl_tag,
    input  logic [2:0]  i_cpl_status,
    input  logic [11:0] i_cpl_byte_count,
    input  logic [12:0] i_cpl_payload_bytes,
    output logic        o_done_valid,
    output logic [9:0]  o_done_tag,
    output logic [2:0]  o_done_status,
    output logic        o_err_unexpected,
    output logic [9:0]  o_outstanding_cnt,
    output logic        o_mode_10bit
);

    localparam int IW       = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int USABLE_8 = (NUM_TAGS > 256) ? 256 : NUM_TAGS;

    tag_entry_t      r_ent [NUM_TAGS];
    logic [PW-1:0]   r_presc;
    logic            r_mode;
    logic            r_done_valid;
    logic [9:0]      r_done_tag;
    logic [2:0]      r_done_status;
    logic            r_err;
    logic [9:0]      r_out;

    logic [9:0]          w_base;
    logic [NUM_TAGS-1:0] w_free_vec;
    logic [NUM_TAGS-1:0] w_exp_vec;
    logic [IW-1:0]       w_free_idx;
    logic                w_free_found;
    logic [IW-1:0]       w_exp_idx;
    logic                w_exp_found;
    logic [9:0]          w_cpl_off;
    logic                w_cpl_in_range;
    logic [IW-1:0]       w_cpl_idx;
    tag_entry_t          w_sel;
    logic                w_cpl_hit;
    logic                w_cpl_err;
    logic [12:0]         w_cpl_bc;
    logic                w_cpl_retire;
    logic [2:0]          w_cpl_status;
    logic                w_grant;
    logic                w_to_retire;
    logic                w_retire;
    logic                w_tick;

    assign w_base = r_mode ? 10'(TAG_BASE_10BIT) : 10'd0;

    // In 8-bit mode only the first 256 entries can be addressed by a tag.
    // An entry receiving a completion this cycle is hidden from the timeout
    // scanner, since the completion clears its expiry.
    always_comb begin
        w_free_vec = '0;
        w_exp_vec  = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_free_vec[i] = !r_ent[i].busy && (r_mode || (i < USABLE_8));
            w_exp_vec[i]  = r_ent[i].busy && r_ent[i].expired &&
                            !(w_cpl_hit && (w_cpl_idx == IW'(i)));
        end
    end

    tlp_tag_prio_enc #(.N(NUM_TAGS), .IW(IW)) u_free_enc (
        .i_vec   (w_free_vec),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    tlp_tag_prio_enc #(.N(NUM_TAGS), .IW(IW)) u_exp_enc (
        .i_vec   (w_exp_vec),
        .o_idx   (w_exp_idx),
        .o_found (w_exp_found)
    );

    assign o_alloc_ready = w_free_found;
    assign o_alloc_tag   = w_base + 10'(w_free_idx);
    assign w_grant       = i_alloc_valid && w_free_found;

    // In 10-bit mode tags below the base are rejected outright
    assign w_cpl_off      = i_cpl_tag - w_base;
    assign w_cpl_in_range = r_mode ?
                            ((i_cpl_tag[9:8] != 2'b00) && ({1'b0, w_cpl_off} < 11'(NUM_TAGS))) :
                            ({1'b0, i_cpl_tag} < 11'(USABLE_8));
    assign w_cpl_idx      = w_cpl_off[IW-1:0];
    assign w_sel          = r_ent[w_cpl_idx];
    assign w_cpl_hit      = i_cpl_valid && w_cpl_in_range && w_sel.busy;
    assign w_cpl_err      = i_cpl_valid && !w_cpl_hit;
    assign w_cpl_bc       = decode_byte_count(i_cpl_byte_count);

    // Classify a completion that landed on a busy entry; a partial completion
    // leaves w_cpl_retire low and just shrinks the remaining count.
    always_comb begin
        w_cpl_retire = 1'b0;
        w_cpl_status = ST_SC;
        if (w_cpl_hit) begin
            if (i_cpl_status != ST_SC) begin
                w_cpl_retire = 1'b1;
                w_cpl_status = i_cpl_status;
            end else if (w_cpl_bc != w_sel.remaining) begin
                w_cpl_retire = 1'b1;
                w_cpl_status = ST_MISMATCH;
            end else if (w_cpl_bc <= i_cpl_payload_bytes) begin
                w_cpl_retire = 1'b1;
                w_cpl_status = ST_SC;
            end
        end
    end

    assign w_to_retire = w_exp_found && !w_cpl_retire;
    assign w_retire    = w_cpl_retire || w_to_retire;
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));

    // Per-entry update: a grant, a completion and a timeout retirement always
    // target different entries, so each entry sees at most one of them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (w_grant && (w_free_idx == IW'(i))) begin
                    r_ent[i].busy      <= 1'b1;
                    r_ent[i].expired   <= 1'b0;
                    r_ent[i].remaining <= i_alloc_byte_count;
                    r_ent[i].timer     <= 8'(TIMEOUT_TICKS);
                end else if (w_cpl_hit && (w_cpl_idx == IW'(i))) begin
                    r_ent[i].expired <= 1'b0;
                    if (w_cpl_retire) begin
                        r_ent[i].busy <= 1'b0;
                    end else begin
                        r_ent[i].remaining <= r_ent[i].remaining - i_cpl_payload_bytes;
                        r_ent[i].timer     <= 8'(TIMEOUT_TICKS);
                    end
                end else if (w_to_retire && (w_exp_idx == IW'(i))) begin
                    r_ent[i].busy    <= 1'b0;
                    r_ent[i].expired <= 1'b0;
                end else if (w_tick && r_ent[i].busy && !r_ent[i].expired) begin
                    r_ent[i].timer <= r_ent[i].timer - 8'd1;
                    if (r_ent[i].timer == 8'd1) begin
                        r_ent[i].expired <= 1'b1;
                    end
                end
            end
        end
    end

    // Prescaler, mode latch, retirement/error strobes and busy count.
    // The mode may only change while nothing is outstanding so tags never
    // straddle the two numbering schemes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc       <= '0;
            r_mode        <= 1'b0;
            r_done_valid  <= 1'b0;
            r_done_tag    <= '0;
            r_done_status <= '0;
            r_err         <= 1'b0;
            r_out         <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if ((r_out == 10'd0) && !w_grant) begin
                r_mode <= i_tag_10bit_en && (SUPPORT_10BIT_TAG != 0);
            end
            r_done_valid <= w_retire;
            if (w_cpl_retire) begin
                r_done_tag    <= w_base + 10'(w_cpl_idx);
                r_done_status <= w_cpl_status;
            end else if (w_to_retire) begin
                r_done_tag    <= w_base + 10'(w_exp_idx);
                r_done_status <= ST_TIMEOUT;
            end
            r_err <= w_cpl_err;
            r_out <= r_out + 10'(w_grant) - 10'(w_retire);
        end
    end

    assign o_done_valid      = r_done_valid;
    assign o_done_tag        = r_done_tag;
    assign o_done_status     = r_done_status;
    assign o_err_unexpected  = r_err;
    assign o_outstanding_cnt = r_out;
    assign o_mode_10bit      = r_mode;

endmodule

// File: tb/tb_tlp_tag_tracker.sv
// Scoreboard bench for tlp_tag_tracker: a transaction-level model predicts
// retirements and error pulses, queues them, and an independent monitor
// matches them against what the tracker presents.
module tb_tlp_tag_tracker;

    localparam int NT  = 4;
    localparam int TD  = 4;
    localparam int TO  = 2;

    typedef struct {
        int stamp;
        int tag;
        int st;
    } doneItem_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tag10En = 1'b0;
    logic        allocValid = 1'b0;
    logic [12:0] allocBc = 13'd1;
    logic        allocReady;
    logic [9:0]  allocTag;
    logic        cplValid = 1'b0;
    logic [9:0]  cplTag = '0;
    logic [2:0]  cplStatus = '0;
    logic [11:0] cplBc = '0;
    logic [12:0] cplPay = '0;
    logic        doneValid;
    logic [9:0]  doneTag;
    logic [2:0]  doneStatus;
    logic        errUnexp;
    logic [9:0]  outCnt;
    logic        mode10;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    bit curEn = 1'b0;

    doneItem_t doneQ[$];
    int        errQ[$];

    // Reference model state
    bit mBusy [NT];
    bit mExp  [NT];
    int mRem  [NT];
    int mTicks[NT];
    bit mMode;
    int mOut;
    int mPresc;

    tlp_tag_tracker #(
        .SUPPORT_10BIT_TAG (1),
        .NUM_TAGS          (NT),
        .TICK_DIV          (TD),
        .TIMEOUT_TICKS     (TO)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_tag_10bit_en      (tag10En),
        .i_alloc_valid       (allocValid),
        .i_alloc_byte_count  (allocBc),
        .o_alloc_ready       (allocReady),
        .o_alloc_tag         (allocTag),
        .i_cpl_valid         (cplValid),
        .i_cpl_tag           (cplTag),
        .i_cpl_status        (cplStatus),
        .i_cpl_byte_count    (cplBc),
        .i_cpl_payload_bytes (cplPay),
        .o_done_valid        (doneValid),
        .o_done_tag          (doneTag),
        .o_done_status       (doneStatus),
        .o_err_unexpected    (errUnexp),
        .o_outstanding_cnt   (outCnt),
        .o_mode_10bit        (mode10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NT; i++) begin
            mBusy[i] = 0; mExp[i] = 0; mRem[i] = 0; mTicks[i] = 0;
        end
        mMode = 0; mOut = 0; mPresc = 0;
        doneQ.delete();
        errQ.delete();
    endtask

    // Drive one cycle of stimulus (called at a falling edge), check the
    // directly observable state, advance the model across the next rising
    // edge and queue whatever the tracker must report afterwards.
    task automatic applyStimulus(input bit av, input int abc, input bit cv, input int ctag,
                                 input int cst, input int cbc, input int cpay);
        int base, freeIdx, hitIdx, rIdx, rSt, off, bcv;
        bit grant, retire, hitRetire, tick;
        allocValid = av; allocBc = 13'(abc);
        cplValid = cv; cplTag = 10'(ctag); cplStatus = 3'(cst);
        cplBc = 12'(cbc); cplPay = 13'(cpay); tag10En = curEn;

        base = mMode ? 256 : 0;
        freeIdx = -1;
        for (int i = NT - 1; i >= 0; i--) if (!mBusy[i]) freeIdx = i;
        checkOutput("outstanding_cnt", int'(outCnt), mOut);
        checkOutput("mode_10bit", int'(mode10), int'(mMode));
        checkOutput("alloc_ready", int'(allocReady), int'(freeIdx >= 0));
        if (freeIdx >= 0) checkOutput("alloc_tag", int'(allocTag), base + freeIdx);

        grant = av && (freeIdx >= 0);
        hitIdx = -1; retire = 0; hitRetire = 0; rIdx = -1; rSt = 0;
        if (cv) begin
            off = ctag - base;
            if (off >= 0 && off < NT && mBusy[off]) hitIdx = off;
            else errQ.push_back(edgeCnt);
        end
        if (hitIdx >= 0) begin
            bcv = (cbc == 0) ? 4096 : cbc;
            if (cst != 0)            begin hitRetire = 1; rSt = cst; end
            else if (bcv != mRem[hitIdx]) begin hitRetire = 1; rSt = 6; end
            else if (bcv <= cpay)    begin hitRetire = 1; rSt = 0; end
            if (hitRetire) begin retire = 1; rIdx = hitIdx; end
        end
        if (!retire) begin
            for (int i = NT - 1; i >= 0; i--)
                if (mBusy[i] && mExp[i] && i != hitIdx) begin rIdx = i; rSt = 7; end
            retire = (rIdx >= 0);
        end
        tick = (mPresc == TD - 1);
        mPresc = tick ? 0 : mPresc + 1;
        for (int i = 0; i < NT; i++) begin
            if (tick && mBusy[i] && !mExp[i] && i != hitIdx && !(retire && i == rIdx)) begin
                mTicks[i]--;
                if (mTicks[i] == 0) mExp[i] = 1;
            end
        end
        if (retire) begin
            mBusy[rIdx] = 0; mExp[rIdx] = 0;
            doneQ.push_back('{stamp: edgeCnt, tag: base + rIdx, st: rSt});
        end
        if (hitIdx >= 0 && !hitRetire) begin
            mRem[hitIdx] -= cpay; mTicks[hitIdx] = TO; mExp[hitIdx] = 0;
        end
        if (grant) begin
            mBusy[freeIdx] = 1; mExp[freeIdx] = 0; mRem[freeIdx] = abc; mTicks[freeIdx] = TO;
        end
        if (mOut == 0 && !grant) mMode = curEn;
        mOut += int'(grant) - int'(retire);

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && mOut != 0; n++) idle();
        checkOutput("drain_timeout", mOut, 0);
        idle();
    endtask

    task automatic waitPrescZero();
        for (int n = 0; n < TD && mPresc != 0; n++) idle();
    endtask

    // Monitor: pops the scoreboard whenever the tracker reports something
    initial begin
        doneItem_t it;
        int last;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                last = edgeCnt - 1;
                if (doneValid) begin
                    if (doneQ.size() == 0 || doneQ[0].stamp != last) begin
                        checks++; errors++;
                        $display("[TB] FAIL done_unexpected actual tag=%0d status=%0d required no done (t=%0t)",
                                 doneTag, doneStatus, $time);
                    end else begin
                        it = doneQ.pop_front();
                        checkOutput("done_tag", int'(doneTag), it.tag);
                        checkOutput("done_status", int'(doneStatus), it.st);
                    end
                end else if (doneQ.size() > 0 && doneQ[0].stamp <= last) begin
                    it = doneQ.pop_front();
                    checks++; errors++;
                    $display("[TB] FAIL done_missing actual none required tag=%0d status=%0d (t=%0t)",
                             it.tag, it.st, $time);
                end
                if (errUnexp) begin
                    if (errQ.size() == 0 || errQ[0] != last) begin
                        checks++; errors++;
                        $display("[TB] FAIL err_unexpected actual=1 required=0 (t=%0t)", $time);
                    end else begin
                        checks++;
                        void'(errQ.pop_front());
                    end
                end else if (errQ.size() > 0 && errQ[0] <= last) begin
                    void'(errQ.pop_front());
                    checks++; errors++;
                    $display("[TB] FAIL err_missing actual=0 required=1 (t=%0t)", $time);
                end
            end
        end
    end

    initial begin
        int k, rem, ctag, cst, cbc, cpay, abc, stList[3];
        bit av, cv;
        stList = '{1, 2, 4};
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_outstanding", int'(outCnt), 0);
        checkOutput("rst_done_valid", int'(doneValid), 0);
        checkOutput("rst_mode", int'(mode10), 0);
        checkOutput("rst_err", int'(errUnexp), 0);
        checkOutput("rst_done_tag", int'(doneTag), 0);
        rst_n = 1'b1;

        // Four allocations fill the table
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill_alloc_tag", int'(allocTag), i);
            applyStimulus(1, 256, 0, 0, 0, 0, 1);
            if (i == 2) checkOutput("fill_outstanding3", int'(outCnt), 3);
        end
        checkOutput("fill_ready_low", int'(allocReady), 0);
        drain();

        // Split completion: 256 bytes delivered as 128 + 128
        applyStimulus(1, 256, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 256, 128);
        checkOutput("split_no_done", int'(doneValid), 0);
        applyStimulus(0, 1, 1, 0, 0, 128, 128);
        checkOutput("split_done_valid", int'(doneValid), 1);
        checkOutput("split_done_tag", int'(doneTag), 0);
        checkOutput("split_done_st", int'(doneStatus), 0);
        checkOutput("split_freed", int'(allocTag), 0);

        // Unexpected completions
        applyStimulus(0, 1, 1, 5, 0, 4, 4);
        checkOutput("err_tag5", int'(errUnexp), 1);
        applyStimulus(0, 1, 1, 300, 0, 4, 4);
        checkOutput("err_tag300", int'(errUnexp), 1);
        applyStimulus(0, 1, 1, 2, 0, 4, 4);

        // Unsupported request, then byte count mismatch
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 1, 64, 64);
        checkOutput("ur_status", int'(doneStatus), 1);
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 32, 32);
        checkOutput("mismatch_status", int'(doneStatus), 6);
        drain();

        // Simultaneous expiry, then a completion racing an expiry
        waitPrescZero();
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        drain();
        waitPrescZero();
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        for (int n = 0; n < 40 && !mExp[0]; n++) idle();
        applyStimulus(0, 1, 1, 0, 0, 64, 64);
        checkOutput("race_done_st", int'(doneStatus), 0);
        drain();

        // 10-bit tag mode
        curEn = 1'b1;
        idle();
        checkOutput("mode10_set", int'(mode10), 1);
        checkOutput("mode10_tag", int'(allocTag), 256);
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        curEn = 1'b0;
        applyStimulus(0, 1, 1, 256, 0, 64, 32);
        checkOutput("mode10_hold", int'(mode10), 1);
        applyStimulus(0, 1, 1, 256, 0, 32, 32);
        checkOutput("mode10_done_tag", int'(doneTag), 256);
        applyStimulus(0, 1, 1, 5, 0, 4, 4);
        drain();

        // Reset in the middle of activity discards everything
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        applyStimulus(1, 64, 0, 0, 0, 0, 1);
        #1 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_outstanding", int'(outCnt), 0);
        checkOutput("midrst_ready", int'(allocReady), 1);
        repeat (2) @(negedge clk);
        checkOutput("midrst_no_done", int'(doneValid), 0);
        rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            av = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: abc = 64;
                1: abc = 256;
                2: abc = 4096;
                default: abc = $urandom_range(1, 4096);
            endcase
            cv = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, NT - 1);
            ctag = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : (mMode ? 256 : 0) + k;
            cst = ($urandom_range(0, 7) == 0) ? stList[$urandom_range(0, 2)] : 0;
            rem = mBusy[k] ? mRem[k] : 64;
            if (rem < 1) rem = 1;
            cbc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4095) : rem % 4096;
            cpay = ($urandom_range(0, 1) == 0) ? rem : $urandom_range(1, rem);
            if ($urandom_range(0, 15) == 0) curEn = ~curEn;
            applyStimulus(av, abc, cv, ctag, cst, cbc, cpay);
        end
        curEn = 1'b0;
        drain();
        repeat (3) idle();
        checkOutput("final_doneq_empty", doneQ.size(), 0);
        checkOutput("final_errq_empty", errQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
